// File: rtl/master_addr_pkg.sv
// Shared definitions for the master address FIFO: burst encodings, packed-word field offsets
// and the packed width, used by both the write-side packer and the read-side drain.
package master_addr_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Packed word is {id, addr, len[7:0], burst[1:0]}, MSB to LSB.
    localparam int unsigned BURST_LSB = 0;
    localparam int unsigned LEN_LSB   = 2;
    localparam int unsigned ADDR_LSB  = 10;

    function automatic int unsigned fifo_width(input int unsigned id_w,
                                               input int unsigned addr_w);
        return id_w + addr_w + 10;
    endfunction

    function automatic int unsigned id_lsb(input int unsigned addr_w);
        return ADDR_LSB + addr_w;
    endfunction

endpackage

// File: rtl/master_addr_fifo_drain_if.sv
// FIFO read port plus AXI address channel seen by the drain; master = drain side,
// slave = FIFO/interconnect side.
interface master_addr_fifo_drain_if
    import master_addr_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_WIDTH = fifo_width(ID_WIDTH, ADDR_WIDTH)
) ();

    logic                  fifo_rd_en;
    logic                  fifo_rd_empty;
    logic [FIFO_WIDTH-1:0] fifo_rd_data;

    logic [ID_WIDTH-1:0]   axi_id;
    logic [ADDR_WIDTH-1:0] axi_addr;
    logic [7:0]            axi_len;
    logic [1:0]            axi_burst;
    logic                  axi_valid;
    logic                  axi_ready;
    logic                  txn_done;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_empty,
        input  fifo_rd_data,
        output axi_id,
        output axi_addr,
        output axi_len,
        output axi_burst,
        output axi_valid,
        input  axi_ready,
        input  txn_done
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_empty,
        output fifo_rd_data,
        input  axi_id,
        input  axi_addr,
        input  axi_len,
        input  axi_burst,
        input  axi_valid,
        output axi_ready,
        output txn_done
    );

endinterface

// File: rtl/master_addr_skid2.sv
// Two-entry pointer FIFO that absorbs the one-cycle read latency of the async FIFO.
// The caller guarantees no push while full.
module master_addr_skid2 #(
    parameter int unsigned WIDTH = 46
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       occ_q, occ_d;

    always_comb begin
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/master_addr_fifo_drain.sv
// Pops packed address words from the async FIFO read port and issues them on an AXI AW/AR
// channel, capping the number of issued-but-not-completed bursts.
module master_addr_fifo_drain
    import master_addr_pkg::*;
#(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned FIFO_WIDTH      = fifo_width(ID_WIDTH, ADDR_WIDTH),
    parameter int unsigned OUTSTANDING_MAX = 8,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    master_addr_fifo_drain_if.master bus,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  idle
);

    logic                  inflight_q;
    logic [1:0]            occ;
    logic [FIFO_WIDTH-1:0] head;
    logic                  pop;
    logic                  dec;
    logic [2:0]            fill;
    logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;

    master_addr_skid2 #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight_q),
        .push_data (bus.fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    // Gate uses registered count only, and the count moves up solely on handshake,
    // so a raised valid can never be withdrawn before it is accepted.
    assign bus.axi_valid = (occ != 2'd0) && (outstanding_q < CNT_WIDTH'(OUTSTANDING_MAX));
    assign pop           = bus.axi_valid && bus.axi_ready;

    // Request only if the word will have a free slot when it lands next cycle.
    assign fill           = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign bus.fifo_rd_en = rstn && !bus.fifo_rd_empty && (fill < 3'd2);

    assign bus.axi_id    = head[id_lsb(ADDR_WIDTH) +: ID_WIDTH];
    assign bus.axi_addr  = head[ADDR_LSB +: ADDR_WIDTH];
    assign bus.axi_len   = head[LEN_LSB +: 8];
    assign bus.axi_burst = head[BURST_LSB +: 2];

    // Completions against an empty count are spurious and dropped.
    assign dec = bus.txn_done && (outstanding_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        if (pop && !dec) begin
            outstanding_d = outstanding_q + CNT_WIDTH'(1);
        end else if (!pop && dec) begin
            outstanding_d = outstanding_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q    <= 1'b0;
            outstanding_q <= '0;
        end else begin
            inflight_q    <= bus.fifo_rd_en;
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding = outstanding_q;
    assign idle        = (occ == 2'd0) && !inflight_q && (outstanding_q == '0);

endmodule
